// File: rtl/stparam_pkg.sv
// rtl/stparam_pkg.sv - shared types and helpers for the parameter-fetch sequencer
package stparam_pkg;

    localparam int NPAR_MAX = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } stparam_state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } stparam_nsb_t;

    // Lowest set bit of mask at a position >= start (start may be NPAR_MAX).
    function automatic stparam_nsb_t next_set_bit(input logic [NPAR_MAX-1:0] mask,
                                                  input logic [3:0]          start);
        stparam_nsb_t r;
        r.found = 1'b0;
        r.idx   = 3'd0;
        for (int i = NPAR_MAX - 1; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= start)) begin
                r.found = 1'b1;
                r.idx   = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stparam_seq_prienc.sv
// rtl/stparam_seq_prienc.sv - lowest set mask bit at or above a start index
module stparam_prienc
    import stparam_pkg::*;
#(
    parameter int NPAR = 3,
    parameter int IDXW = 2
) (
    input  logic [NPAR-1:0] mask_i,
    input  logic [IDXW:0]   start_i,
    output logic            found_o,
    output logic [IDXW-1:0] idx_o
);

    stparam_nsb_t r;

    always_comb begin
        r       = next_set_bit(NPAR_MAX'(mask_i), 4'(start_i));
        found_o = r.found;
        idx_o   = IDXW'(r.idx);
    end

endmodule

// File: rtl/stparam_seq.sv
// rtl/stparam_seq.sv - masked NPAR-word blitter parameter fetch sequencer
// Optional ABORT input enabled by defining STPARAM_ABORT_EN.
module stparam_seq
    import stparam_pkg::*;
#(
    parameter int NPAR = 3,
    parameter int IDXW = (NPAR > 1) ? $clog2(NPAR) : 1
) (
    input  logic            CCLK,
    input  logic            SRESET,
    input  logic            RDPAR,
    input  logic [NPAR-1:0] PARMASK,
    input  logic            CYCEND,
    input  logic            ICYCEND,
`ifdef STPARAM_ABORT_EN
    input  logic            ABORT,
`endif
    output logic            PARCRQ,
    output logic [IDXW-1:0] PARIDX,
    output logic [NPAR-1:0] LDPARL,
    output logic            PARDN,
    output logic            PARBUSY
);

    stparam_state_t  state_q, state_d;
    logic [NPAR-1:0] mask_q, mask_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [NPAR-1:0] ldparl_q, ldparl_d;
    logic            pardn_q, pardn_d;
    logic            busy_q;
    logic            abort;
    logic            first_found, adv_found;
    logic [IDXW-1:0] first_idx, adv_idx;
    logic [IDXW:0]   adv_start;

`ifdef STPARAM_ABORT_EN
    assign abort = ABORT;
`else
    assign abort = 1'b0;
`endif

    assign adv_start = {1'b0, idx_q} + {{IDXW{1'b0}}, 1'b1};

    stparam_prienc #(.NPAR(NPAR), .IDXW(IDXW)) u_first (
        .mask_i  (PARMASK),
        .start_i ('0),
        .found_o (first_found),
        .idx_o   (first_idx)
    );

    stparam_prienc #(.NPAR(NPAR), .IDXW(IDXW)) u_adv (
        .mask_i  (mask_q),
        .start_i (adv_start),
        .found_o (adv_found),
        .idx_o   (adv_idx)
    );

    always_ff @(posedge CCLK) begin
        if (SRESET) begin
            state_q  <= ST_IDLE;
            mask_q   <= '0;
            idx_q    <= '0;
            ldparl_q <= '1;
            pardn_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            idx_q    <= idx_d;
            ldparl_q <= ldparl_d;
            pardn_q  <= pardn_d;
            busy_q   <= (state_d == ST_FETCH);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (RDPAR && first_found) state_d = ST_FETCH;
            ST_FETCH: if (abort || (CYCEND && !adv_found)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Strobe for ICYCEND uses the current idx even when CYCEND advances it on the same edge.
    always_comb begin
        mask_d   = mask_q;
        idx_d    = idx_q;
        ldparl_d = '1;
        pardn_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (RDPAR) begin
                mask_d = PARMASK;
                if (first_found) idx_d = first_idx;
                else             pardn_d = 1'b1;
            end
        end else if (!abort) begin
            if (ICYCEND) begin
                for (int i = 0; i < NPAR; i++) begin
                    if (IDXW'(i) == idx_q) ldparl_d[i] = 1'b0;
                end
                pardn_d = !adv_found;
            end
            if (CYCEND && adv_found) idx_d = adv_idx;
        end
    end

    always_comb begin
        PARCRQ = (state_d == ST_FETCH) && !SRESET;
    end

    assign PARIDX  = idx_q;
    assign LDPARL  = ldparl_q;
    assign PARDN   = pardn_q;
    assign PARBUSY = busy_q;

endmodule

// File: tb/tb_stparam_seq.sv
// tb/tb_stparam_seq.sv - directed self-checking bench for stparam_seq (NPAR=3)
module tb_stparam_seq;

    logic       clk = 1'b0;
    logic       sreset = 1'b0;
    logic       rdpar = 1'b0;
    logic [2:0] parmask = 3'b000;
    logic       cycend = 1'b0;
    logic       icycend = 1'b0;
    logic       abort_in = 1'b0;
    logic       parcrq;
    logic [1:0] paridx;
    logic [2:0] ldparl;
    logic       pardn;
    logic       parbusy;
    int         checks = 0;
    int         failures = 0;

    stparam_seq #(.NPAR(3)) dut (
        .CCLK    (clk),
        .SRESET  (sreset),
        .RDPAR   (rdpar),
        .PARMASK (parmask),
        .CYCEND  (cycend),
        .ICYCEND (icycend),
`ifdef STPARAM_ABORT_EN
        .ABORT   (abort_in),
`endif
        .PARCRQ  (parcrq),
        .PARIDX  (paridx),
        .LDPARL  (ldparl),
        .PARDN   (pardn),
        .PARBUSY (parbusy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One word: ICYCEND clock then CYCEND clock.
    task automatic fetch_word(input string tag, input logic [2:0] strobe, input logic last,
                              input logic [1:0] next_idx);
        icycend = 1'b1; cycend = 1'b0;
        #1 chk({tag, "_crq_icyc"}, parcrq, 1);
        tick;
        chk({tag, "_ldparl"}, ldparl, strobe);
        chk({tag, "_pardn"}, pardn, last);
        icycend = 1'b0; cycend = 1'b1;
        #1 chk({tag, "_crq_cyc"}, parcrq, !last);
        tick;
        cycend = 1'b0;
        chk({tag, "_ldparl_idle"}, ldparl, 3'b111);
        chk({tag, "_pardn_off"}, pardn, 0);
        chk({tag, "_busy"}, parbusy, !last);
        if (!last) chk({tag, "_idx_next"}, paridx, next_idx);
    endtask

    task automatic start_seq(input string tag, input logic [2:0] m, input logic [1:0] idx0);
        rdpar = 1'b1; parmask = m;
        #1 chk({tag, "_crq_start"}, parcrq, 1);
        tick;
        rdpar = 1'b0;
        chk({tag, "_busy_start"}, parbusy, 1);
        chk({tag, "_idx_start"}, paridx, idx0);
    endtask

    initial begin
        // reset, with RDPAR high to confirm PARCRQ is held low
        sreset = 1'b1; rdpar = 1'b1; parmask = 3'b111;
        tick;
        #1 chk("rst_crq", parcrq, 0);
        tick;
        chk("rst_ldparl", ldparl, 3'b111);
        chk("rst_pardn", pardn, 0);
        chk("rst_busy", parbusy, 0);
        chk("rst_idx", paridx, 0);
        sreset = 1'b0; rdpar = 1'b0;
        tick;

        // full mask
        start_seq("full", 3'b111, 2'd0);
        fetch_word("full_w0", 3'b110, 1'b0, 2'd1);
        fetch_word("full_w1", 3'b101, 1'b0, 2'd2);
        fetch_word("full_w2", 3'b011, 1'b1, 2'd0);

        // sparse mask
        start_seq("sparse", 3'b101, 2'd0);
        fetch_word("sparse_w0", 3'b110, 1'b0, 2'd2);
        fetch_word("sparse_w2", 3'b011, 1'b1, 2'd0);

        // zero mask
        rdpar = 1'b1; parmask = 3'b000;
        #1 chk("zero_crq0", parcrq, 0);
        tick;
        rdpar = 1'b0;
        chk("zero_pardn", pardn, 1);
        chk("zero_busy", parbusy, 0);
        chk("zero_ldparl", ldparl, 3'b111);
        #1 chk("zero_crq1", parcrq, 0);
        tick;
        chk("zero_pardn_off", pardn, 0);

        // coincident ICYCEND/CYCEND with RDPAR held high
        rdpar = 1'b1; parmask = 3'b111;
        #1 chk("coin_crq_start", parcrq, 1);
        tick;
        chk("coin_busy", parbusy, 1);
        chk("coin_idx0", paridx, 0);
        icycend = 1'b1; cycend = 1'b1;
        tick;
        chk("coin_ldparl0", ldparl, 3'b110);
        chk("coin_idx1", paridx, 1);
        chk("coin_pardn0", pardn, 0);
        tick;
        chk("coin_ldparl1", ldparl, 3'b101);
        chk("coin_idx2", paridx, 2);
        #1 chk("coin_crq_final", parcrq, 0);
        tick;
        icycend = 1'b0; cycend = 1'b0;
        chk("coin_ldparl2", ldparl, 3'b011);
        chk("coin_pardn2", pardn, 1);
        chk("coin_busy_idle", parbusy, 0);
        #1 chk("coin_crq_restart", parcrq, 1);
        tick;
        rdpar = 1'b0;
        chk("coin_restart_busy", parbusy, 1);
        chk("coin_restart_idx", paridx, 0);
        chk("coin_restart_ldparl", ldparl, 3'b111);

        // reset mid-sequence during word 1 with ICYCEND
        icycend = 1'b1; cycend = 1'b1;
        tick;
        chk("mid_idx1", paridx, 1);
        cycend = 1'b0; sreset = 1'b1;
        #1 chk("mid_rst_crq", parcrq, 0);
        tick;
        sreset = 1'b0; icycend = 1'b0;
        chk("mid_rst_ldparl", ldparl, 3'b111);
        chk("mid_rst_pardn", pardn, 0);
        chk("mid_rst_busy", parbusy, 0);
        chk("mid_rst_idx", paridx, 0);

        // strobes ignored in IDLE
        icycend = 1'b1; cycend = 1'b1;
        #1 chk("idle_crq", parcrq, 0);
        tick;
        icycend = 1'b0; cycend = 1'b0;
        chk("idle_ldparl", ldparl, 3'b111);
        chk("idle_pardn", pardn, 0);
        chk("idle_busy", parbusy, 0);

`ifdef STPARAM_ABORT_EN
        // abort at word 2 together with ICYCEND
        start_seq("abt", 3'b111, 2'd0);
        fetch_word("abt_w0", 3'b110, 1'b0, 2'd1);
        fetch_word("abt_w1", 3'b101, 1'b0, 2'd2);
        abort_in = 1'b1; icycend = 1'b1;
        #1 chk("abt_crq", parcrq, 0);
        tick;
        abort_in = 1'b0; icycend = 1'b0;
        chk("abt_ldparl", ldparl, 3'b111);
        chk("abt_pardn", pardn, 0);
        chk("abt_busy", parbusy, 0);
        tick;
        chk("abt_pardn_later", pardn, 0);
        start_seq("abt_re", 3'b111, 2'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
